// File: rtl/encoder_8to3_serial.sv
// rtl/encoder_8to3_serial.sv - sequential 8-to-3 encoder, one index per handshake beat
//
// Captures a multi-hot 8-bit vector and walks its set bits in priority order,
// emitting each bit's binary index on a valid/ready output stream.
//
// Parameters:
//   LSB_FIRST  1: lowest set index first, 0: highest set index first
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   in_vec valid this cycle
//   in_ready   block can accept a vector this cycle
//   in_vec     multi-hot vector to encode
//   out_valid  out_idx / out_seq / out_last valid
//   out_ready  consumer accepts the current beat
//   out_idx    binary index of the current set bit
//   out_seq    ordinal of this beat within the vector
//   out_last   current beat is the final set bit of the vector
//   zero_vec   one-cycle pulse after an all-zero vector is accepted
module encoder_8to3_serial #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_vec,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] out_idx,
    output logic [2:0] out_seq,
    output logic       out_last,
    output logic       zero_vec
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t     state;
    logic [7:0] pending;
    logic [2:0] seq_q;
    logic       zero_q;

    logic [2:0] prio_idx;
    logic       single_bit;
    logic       emit;

    // Priority encoder over the registered pending bits. The loop direction is
    // chosen so that the last match written is the winning bit.
    always_comb begin
        prio_idx = 3'd0;
        if (LSB_FIRST) begin
            for (int i = 7; i >= 0; i--) begin
                if (pending[i]) prio_idx = 3'(i);
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (pending[i]) prio_idx = 3'(i);
            end
        end
    end

    // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
    assign single_bit = (pending != 8'h00) && ((pending & (pending - 8'd1)) == 8'h00);

    assign emit      = (state == EMIT);
    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = emit;
    assign out_idx   = emit ? prio_idx : 3'd0;
    assign out_seq   = emit ? seq_q : 3'd0;
    assign out_last  = emit && single_bit;
    assign zero_vec  = zero_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pending <= 8'h00;
            seq_q   <= 3'd0;
            zero_q  <= 1'b0;
        end else begin
            zero_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (in_vec != 8'h00) begin
                            pending <= in_vec;
                            seq_q   <= 3'd0;
                            state   <= EMIT;
                        end else begin
                            zero_q <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        pending <= pending & ~(8'd1 << prio_idx);
                        if (single_bit) begin
                            seq_q <= 3'd0;
                            state <= IDLE;
                        end else begin
                            seq_q <= seq_q + 3'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/encoder_8to3_serial.md
Name: encoder_8to3_serial

Overview:
- Sequential 8-to-3 encoder: the inverse direction of the existing 3-to-8 decoder.
- Captures an 8-bit multi-hot vector and emits the 3-bit index of every set bit, one index per handshake beat, in priority order.
- Sits between request/flag vectors (e.g. decoder-driven enables, interrupt lines) and index-consuming logic that needs binary codes.
- Valid/ready on both sides; one clock, synchronous reset.

Parameters:
- LSB_FIRST, 1: 1 = lowest set index emitted first; 0 = highest set index emitted first.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_vec is valid this cycle
- in_ready  output  1  block can accept a vector this cycle
- in_vec  input  8  multi-hot vector to encode
- out_valid  output  1  out_idx / out_seq / out_last are valid
- out_ready  input  1  consumer accepts current beat
- out_idx  output  3  binary index of current set bit
- out_seq  output  3  ordinal of this beat within the current vector (0..7)
- out_last  output  1  current beat is the final set bit of the vector
- zero_vec  output  1  one-cycle pulse: an all-zero vector was accepted

Behaviour:
- Interface: one clock, clk; synchronous active-high reset, rst.
- Reset (rst=1 at an edge):
  - state=IDLE, pending=8'h00, out_seq=0, zero_vec=0.
  - out_valid=0, out_idx=0, out_last=0.
  - in_ready=0 while rst is high, and 1 in the first cycle after rst deasserts.
- Reset mid-operation discards pending bits; no further beats are emitted for that vector.
- State machine has two states, IDLE and EMIT.
- IDLE:
  - in_ready=1, out_valid=0.
  - in_valid=1 and in_vec!=0: pending<=in_vec, out_seq<=0, next state EMIT.
  - in_valid=1 and in_vec==0: zero_vec=1 for exactly the next cycle; stay IDLE; no output beats.
- EMIT:
  - in_ready=0. in_valid and in_vec are ignored; captured data is unaffected by input changes.
  - out_valid=1.
  - out_idx = priority index of pending: lowest set bit if LSB_FIRST=1, highest if 0.
  - out_last=1 iff pending has exactly one bit set.
  - On out_valid && out_ready:
    - Clear bit out_idx in pending.
    - out_seq<=out_seq+1.
    - If out_last: next state IDLE, out_seq<=0.
  - Without out_ready, all outputs hold stable (no change while stalled).
- Outputs are decoded only from registered state (pending, state, out_seq); there is no combinational path from in_* to out_*.
- Whenever out_valid=0, out_idx, out_last and out_seq read 0.
- Latency:
  - Vector accepted at edge N: first beat valid in cycle N+1.
  - With out_ready held high: k set bits occupy cycles N+1..N+k.
  - in_ready returns to 1 in cycle N+k+1.
  - Throughput: popcount+1 cycles per nonzero vector.
- out_seq never wraps: at most 8 beats per vector, so the maximum value is 7.

Test Plan:
1. LSB_FIRST=1, in_vec=8'b1010_0100, out_ready=1 -> out_idx 2,5,7 in cycles N+1..N+3; out_seq 0,1,2; out_last only on idx 7; in_ready=1 at N+4.
2. Same vector with out_ready=0 for 3 cycles while out_idx=5, and in_valid=1 with in_vec=8'hFF during EMIT -> out_idx=5, out_seq=1, out_valid=1 held for those 3 cycles; 8'hFF ignored; sequence still ends 5,7.
3. in_vec=8'h00 accepted -> zero_vec=1 for one cycle, out_valid stays 0, in_ready stays 1.
4. in_vec=8'hFF, out_ready=1 -> 8 beats idx 0..7, out_seq 0..7, out_last only on beat 7.
5. rst=1 after 2 beats of 8'hFF -> next cycle out_valid=0 and pending cleared; after release, in_vec=8'h01 -> single beat idx 0, out_last=1, out_seq=0.
6. LSB_FIRST=0, in_vec=8'b1010_0100 -> out_idx 7,5,2, out_last on idx 2.
